// File: rtl/bit_packer_ctrl_if.sv
// Handshake and shifter bus for bit_packer_ctrl: code input, flush control,
// external barrel-shifter connection and packed-word output.
interface bit_packer_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_code;
  logic [4:0]  in_len;
  logic        flush_req;
  logic        flush_done;

  logic        shf_enable;
  logic [63:0] shf_pre_data;
  logic [5:0]  shf_pre_len;
  logic [31:0] shf_data_in;
  logic [4:0]  shf_len_in;
  logic [5:0]  shf_current_len;
  logic        shf_data_full;
  logic [31:0] shf_data_to_write;
  logic [63:0] shf_data_out;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [2:0]  out_bytes;

  // slave: the packer itself; master: encoder, shifter and consumer side
  modport slave (
    input  in_valid, in_code, in_len, flush_req,
    input  shf_current_len, shf_data_full, shf_data_to_write, shf_data_out,
    input  out_ready,
    output in_ready, flush_done,
    output shf_enable, shf_pre_data, shf_pre_len, shf_data_in, shf_len_in,
    output out_valid, out_data, out_last, out_bytes
  );

  modport master (
    output in_valid, in_code, in_len, flush_req,
    output shf_current_len, shf_data_full, shf_data_to_write, shf_data_out,
    output out_ready,
    input  in_ready, flush_done,
    input  shf_enable, shf_pre_data, shf_pre_len, shf_data_in, shf_len_in,
    input  out_valid, out_data, out_last, out_bytes
  );
endinterface

// File: rtl/bit_packer_ctrl.sv
// Drives an external 64-bit barrel shifter to pack LSB-first Huffman codes
// into 32-bit words, with residue feedback, output FIFO and end-of-block pad.
module bit_packer_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  bit_packer_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_PAD, S_PADWAIT, S_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [2:0]  bytes;
  } word_t;

  localparam logic [FIFO_AW+1:0] OCC_LIM  = (FIFO_AW+2)'(FIFO_DEPTH - 2);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

  state_t             r_state, w_state_nxt;
  logic               r_inflight;
  logic               r_pad_inflight;
  logic [2:0]         r_pad_bytes;
  logic [63:0]        r_res_data;
  logic [5:0]         r_res_len;
  word_t              r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_count;

  logic [FIFO_AW+1:0] w_occ;
  logic               w_room;
  logic               w_in_ready, w_accept, w_pad_issue, w_enable;
  logic [31:0]        w_mask;
  logic [4:0]         w_pad_len;
  logic               w_push, w_pop, w_out_valid;
  word_t              w_push_word, w_head;

  // Words already queued plus one that may still land from the shifter
  assign w_occ  = {1'b0, r_count} + {{(FIFO_AW+1){1'b0}}, r_inflight};
  assign w_room = (w_occ <= OCC_LIM);

  assign w_in_ready  = ~reset & ((r_state == S_IDLE) | (r_state == S_RUN)) & w_room;
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_pad_issue = ~reset & (r_state == S_PAD) & w_room;
  assign w_enable    = w_accept | w_pad_issue;

  assign w_mask    = (32'h1 << bus.in_len) - 32'h1;
  assign w_pad_len = 5'(6'd32 - r_res_len);

  assign bus.in_ready     = w_in_ready;
  assign bus.flush_done   = (r_state == S_DONE);
  assign bus.shf_enable   = w_enable;
  // Back-to-back issue takes the residue straight from the shifter result
  assign bus.shf_pre_data = r_inflight ? bus.shf_data_out    : r_res_data;
  assign bus.shf_pre_len  = r_inflight ? bus.shf_current_len : r_res_len;
  assign bus.shf_data_in  = w_accept ? (bus.in_code & w_mask) : 32'h0;
  assign bus.shf_len_in   = w_pad_issue ? w_pad_len : (w_accept ? bus.in_len : 5'd0);

  assign w_push      = r_inflight & bus.shf_data_full;
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid & bus.out_ready;

  always_comb begin
    w_push_word.data  = bus.shf_data_to_write;
    w_push_word.last  = r_pad_inflight;
    w_push_word.bytes = r_pad_inflight ? r_pad_bytes : 3'd4;
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? w_head.data  : 32'h0;
  assign bus.out_last  = w_out_valid ? w_head.last  : 1'b0;
  assign bus.out_bytes = w_out_valid ? w_head.bytes : 3'd0;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.flush_req)
          w_state_nxt = (w_accept || r_inflight || (r_res_len != 6'd0)) ? S_DRAIN : S_DONE;
        else if (w_accept)
          w_state_nxt = S_RUN;
      end
      S_RUN:     if (bus.flush_req) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (!r_inflight) w_state_nxt = (r_res_len == 6'd0) ? S_DONE : S_PAD;
      S_PAD:     if (w_pad_issue) w_state_nxt = S_PADWAIT;
      S_PADWAIT: w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_inflight     <= 1'b0;
      r_pad_inflight <= 1'b0;
      r_pad_bytes    <= 3'd0;
      r_res_data     <= 64'h0;
      r_res_len      <= 6'd0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_inflight     <= w_enable;
      r_pad_inflight <= w_pad_issue;
      if (w_pad_issue)
        r_pad_bytes <= 3'((r_res_len + 6'd7) >> 3);

      // Pad leaves the shifter empty; clear explicitly so the next block starts clean
      if (r_state == S_PADWAIT) begin
        r_res_data <= 64'h0;
        r_res_len  <= 6'd0;
      end else if (r_inflight) begin
        r_res_data <= bus.shf_data_out;
        r_res_len  <= bus.shf_current_len;
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + (FIFO_AW+1)'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - (FIFO_AW+1)'(1);

      assert (!(w_push && !w_pop && (r_count == FULL_CNT)));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push)
      r_mem[r_wr_ptr] <= w_push_word;
  end
endmodule

// File: tb/tb_bit_packer_ctrl.sv
// Bench for bit_packer_ctrl: behavioural shifter, constant vector table,
// hand sequences for backpressure/reset, and a random run against a bit-queue model.
module tb_bit_packer_ctrl;
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [2:0]  bytes;
  } word_t;

  typedef struct packed {
    logic [1:0]  kind;   // 0 code, 1 code with flush, 2 flush only
    logic [31:0] code;
    logic [4:0]  len;
    logic        has;
    logic [31:0] wdata;
    logic        wlast;
    logic [2:0]  wbytes;
    logic [7:0]  maxlat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bit_packer_ctrl_if bif();

  bit_packer_ctrl #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  // External shifter: one registered stage, outputs zero when not enabled
  logic [63:0] sh_cat, sh_out;
  logic [6:0]  sh_len;
  logic [5:0]  sh_clen;
  logic        sh_full;
  logic [31:0] sh_word;
  assign sh_cat = bif.shf_pre_data | ({32'h0, bif.shf_data_in} << bif.shf_pre_len);
  assign sh_len = {1'b0, bif.shf_pre_len} + {2'b0, bif.shf_len_in};
  always @(posedge clk) begin
    if (reset || !bif.shf_enable) begin
      sh_out <= 64'h0; sh_clen <= 6'd0; sh_full <= 1'b0; sh_word <= 32'h0;
    end else if (sh_len >= 7'd32) begin
      sh_out <= sh_cat >> 32; sh_clen <= 6'(sh_len - 7'd32);
      sh_full <= 1'b1; sh_word <= sh_cat[31:0];
    end else begin
      sh_out <= sh_cat; sh_clen <= sh_len[5:0]; sh_full <= 1'b0; sh_word <= 32'h0;
    end
  end
  assign bif.shf_data_out      = sh_out;
  assign bif.shf_current_len   = sh_clen;
  assign bif.shf_data_full     = sh_full;
  assign bif.shf_data_to_write = sh_word;

  logic rdy_fix, rand_rdy, rnd_bit;
  assign bif.out_ready = rand_rdy ? rnd_bit : rdy_fix;
  always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

  word_t got_q[$];
  always @(negedge clk)
    if (!reset && bif.out_valid && bif.out_ready)
      got_q.push_back({bif.out_data, bif.out_last, bif.out_bytes});

  int    nvec = 0, nbad = 0, got_rd = 0, acc_cnt = 0;
  bit    use_model = 0;
  bit    mbits[$];
  word_t exp_q[$];
  vec_t  tab[18];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_code(input logic [31:0] code, input logic [4:0] len);
    logic [31:0] w;
    for (int i = 0; i < int'(len); i++) mbits.push_back(code[i]);
    while (mbits.size() >= 32) begin
      for (int j = 0; j < 32; j++) w[j] = mbits.pop_front();
      exp_q.push_back({w, 1'b0, 3'd4});
    end
  endtask

  task automatic model_flush();
    logic [31:0] w;
    int n;
    n = mbits.size();
    if (n > 0) begin
      w = 32'h0;
      for (int j = 0; j < n; j++) w[j] = mbits[j];
      exp_q.push_back({w, 1'b1, 3'((n + 7) / 8)});
    end
    mbits.delete();
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bif.flush_done) begin lat = k; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] code, input logic [4:0] len, input logic fl,
                      output int stalls);
    bit ok;
    ok = 0; stalls = 0;
    bif.in_valid = 1'b1; bif.in_code = code; bif.in_len = len;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bif.in_ready) begin bif.flush_req = fl; ok = 1; end
      @(posedge clk); #1;
      if (ok) break;
      stalls++;
    end
    bif.in_valid = 1'b0; bif.flush_req = 1'b0; bif.in_code = 32'h0; bif.in_len = 5'd0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    else begin
      acc_cnt++;
      if (use_model) begin
        model_code(code, len);
        if (fl) model_flush();
      end
    end
  endtask

  task automatic flush_only(output int lat);
    bif.flush_req = 1'b1;
    @(posedge clk); #1;
    bif.flush_req = 1'b0;
    if (use_model) model_flush();
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bif.flush_done) begin lat = k; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int quiet;
    quiet = 0;
    rand_rdy = 0; rdy_fix = 1;
    for (int k = 0; k < 500 && quiet < 4; k++) begin
      @(negedge clk);
      if (bif.out_valid) quiet = 0; else quiet++;
    end
    @(posedge clk); #1;
    if (quiet < 4) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_words(input string tag);
    int ng;
    ng = got_q.size() - got_rd;
    chk({tag, "_count"}, 64'(ng), 64'(exp_q.size()));
    for (int i = 0; i < ng && i < exp_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), 64'(got_q[got_rd + i]), 64'(exp_q[i]));
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  function automatic vec_t mk(input logic [1:0] kind, input logic [31:0] code,
                              input logic [4:0] len, input logic has, input logic [31:0] wd,
                              input logic wl, input logic [2:0] wb, input logic [7:0] ml);
    vec_t v;
    v.kind = kind; v.code = code; v.len = len; v.has = has;
    v.wdata = wd; v.wlast = wl; v.wbytes = wb; v.maxlat = ml;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, stall_sum, lat;
    bit seen;
    logic [31:0] c;
    logic [4:0]  l;
    int r;

    tab[0]  = mk(0, 32'h01, 8, 0, 0, 0, 0, 0);
    tab[1]  = mk(0, 32'h02, 8, 0, 0, 0, 0, 0);
    tab[2]  = mk(0, 32'h03, 8, 0, 0, 0, 0, 0);
    tab[3]  = mk(0, 32'h04, 8, 1, 32'h04030201, 0, 4, 0);
    tab[4]  = mk(0, 32'h05, 8, 0, 0, 0, 0, 0);
    tab[5]  = mk(0, 32'h06, 8, 0, 0, 0, 0, 0);
    tab[6]  = mk(0, 32'h07, 8, 0, 0, 0, 0, 0);
    tab[7]  = mk(0, 32'h08, 8, 1, 32'h08070605, 0, 4, 0);
    tab[8]  = mk(0, 32'hABCDE, 20, 0, 0, 0, 0, 0);
    tab[9]  = mk(0, 32'h12345, 20, 1, 32'h345ABCDE, 0, 4, 0);
    tab[10] = mk(2, 32'h0, 0, 1, 32'h00000012, 1, 1, 40);
    tab[11] = mk(1, 32'h1F, 5, 1, 32'h0000001F, 1, 1, 40);
    tab[12] = mk(0, 32'hABCDFFFF, 16, 0, 0, 0, 0, 0);
    tab[13] = mk(0, 32'h0, 0, 0, 0, 0, 0, 0);
    tab[14] = mk(0, 32'h00001234, 16, 1, 32'h1234FFFF, 0, 4, 0);
    tab[15] = mk(0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    tab[16] = mk(2, 32'h0, 0, 0, 0, 0, 0, 3);
    tab[17] = mk(0, 32'h7, 3, 0, 0, 0, 0, 0);

    bif.in_valid = 0; bif.in_code = 0; bif.in_len = 0; bif.flush_req = 0;
    rdy_fix = 0; rand_rdy = 0;
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_out_valid",  64'(bif.out_valid),    64'd0);
    chk("rst_flush_done", 64'(bif.flush_done),   64'd0);
    chk("rst_shf_enable", 64'(bif.shf_enable),   64'd0);
    chk("rst_pre_len",    64'(bif.shf_pre_len),  64'd0);
    chk("rst_in_ready",   64'(bif.in_ready),     64'd1);
    @(posedge clk); #1;

    // Constant table: expected words spelled out
    rdy_fix = 1; use_model = 0; stall_sum = 0;
    for (int i = 0; i < 18; i++) begin
      if (tab[i].kind == 2'd2) begin
        flush_only(lat);
        chk($sformatf("tab%0d_flush_lat_ok", i), 64'(lat >= 1 && lat <= int'(tab[i].maxlat)), 64'd1);
      end else begin
        send(tab[i].code, tab[i].len, tab[i].kind == 2'd1, st);
        if (i < 8) stall_sum += st;
        if (tab[i].kind == 2'd1) begin
          wait_done(lat);
          chk($sformatf("tab%0d_flush_lat_ok", i), 64'(lat >= 1 && lat <= int'(tab[i].maxlat)), 64'd1);
        end
      end
      if (tab[i].has) exp_q.push_back({tab[i].wdata, tab[i].wlast, tab[i].wbytes});
    end
    chk("tab_stalls_8x8", 64'(stall_sum), 64'd0);
    // close the trailing 3-bit code so the next phase starts with an empty residue
    flush_only(lat);
    exp_q.push_back({32'h00000007, 1'b1, 3'd1});
    drain();
    check_words("tab");

    // Backpressure: consumer stalled while len-31 codes stream in
    use_model = 1; rdy_fix = 0; acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send($urandom, 5'd31, 1'b0, st);
      end
      begin
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready",  64'(bif.in_ready),  64'd0);
        chk("bp_out_valid", 64'(bif.out_valid), 64'd1);
        chk("bp_words_held", 64'((acc_cnt * 31) / 32), 64'd3);
        rdy_fix = 1;
      end
    join
    flush_only(lat);
    chk("bp_flush_done", 64'(lat > 0), 64'd1);
    drain();
    check_words("bp");

    // Reset while the pad beat is being issued with two words queued
    use_model = 0; rdy_fix = 0;
    send(32'hAAAAAA, 5'd24, 1'b0, st);
    send(32'hBBBBBB, 5'd24, 1'b0, st);
    send(32'hCCCCCC, 5'd24, 1'b1, st);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pad_enable",  64'(bif.shf_enable), 64'd1);
    chk("pad_len_in",  64'(bif.shf_len_in), 64'd24);
    chk("pad_queued",  64'(bif.out_valid),  64'd1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("rstpad_out_valid", 64'(bif.out_valid), 64'd0);
    chk("rstpad_in_ready",  64'(bif.in_ready),  64'd1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bif.flush_done) seen = 1;
    end
    chk("rstpad_no_flush_done", 64'(seen), 64'd0);
    @(posedge clk); #1;
    got_rd = got_q.size();
    exp_q.delete(); mbits.delete();
    use_model = 1;
    flush_only(lat);
    chk("rstpad_flush_lat_ok", 64'(lat >= 1 && lat <= 3), 64'd1);
    drain();
    check_words("rstpad");

    // Random codes, random consumer, occasional flushes
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      c = $urandom;
      l = 5'($urandom_range(0, 31));
      r = $urandom_range(0, 19);
      if (r == 0) begin
        send(c, l, 1'b1, st);
        wait_done(lat);
        chk($sformatf("rnd%0d_flush", i), 64'(lat > 0), 64'd1);
      end else if (r == 1) begin
        send(c, l, 1'b0, st);
        flush_only(lat);
        chk($sformatf("rnd%0d_flush", i), 64'(lat > 0), 64'd1);
      end else begin
        send(c, l, 1'b0, st);
      end
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    flush_only(lat);
    chk("rnd_final_flush", 64'(lat > 0), 64'd1);
    drain();
    check_words("rnd");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
